// File: rtl/link_pkg.sv
// Shared definitions for the 4-phase link master: FSM state encoding and
// parameter defaults.
package link_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_LOW = 2'd2
  } link_state_e;

  localparam int unsigned LINK_DEPTH_DEFAULT   = 32'd4;
  localparam int unsigned LINK_TIMEOUT_DEFAULT = 32'd15;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/link_master_fsm_if.sv
// Upstream byte stream plus 4-phase slave handshake of the link master.
interface link_master_fsm_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ack;
  logic       req;
  logic [7:0] data_out;
  logic       byte_done;
  logic       busy;
  logic [7:0] sent_count;
  logic       err;

  modport master (
    input  in_valid, in_data, ack,
    output in_ready, req, data_out, byte_done, busy, sent_count, err
  );

  modport slave (
    output in_valid, in_data, ack,
    input  in_ready, req, data_out, byte_done, busy, sent_count, err
  );

endinterface

// File: rtl/link_fifo.sv
// Synchronous DEPTH x 8 transmit FIFO; a push is refused at full even when a
// pop happens in the same cycle.
module link_fifo
  import link_pkg::*;
#(
  parameter int unsigned DEPTH = LINK_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/link_master_fsm.sv
// 4-phase handshake link master fed by a transmit FIFO.
// Optional macro LINK_MASTER_TIMEOUT_EN: abandon a byte if ack never arrives.
module link_master_fsm
  import link_pkg::*;
#(
  parameter int unsigned DEPTH          = LINK_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = LINK_TIMEOUT_DEFAULT,
  localparam int unsigned CW            = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  link_master_fsm_if.master  bus
);

  if (!is_pow2(DEPTH) || (DEPTH < 32'd2) || (DEPTH > 32'd16)) begin : g_bad_depth
    $error("link_master_fsm: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 32'd1) begin : g_bad_timeout
    $error("link_master_fsm: TIMEOUT_CYCLES must be at least 1");
  end

  link_state_e   state_q, state_d;
  logic          req_q, req_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          byte_done_q, byte_done_d;
  logic [7:0]    sent_count_q, sent_count_d;
  logic          fifo_pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_rd_data_s;
  logic [CW-1:0] fifo_count_s;

`ifdef LINK_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
`endif

  link_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.in_valid),
    .pop     (fifo_pop_s),
    .wr_data (bus.in_data),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Handshake next-state; a new request only starts while ack is low.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    data_out_d   = data_out_q;
    byte_done_d  = 1'b0;
    sent_count_d = sent_count_q;
    fifo_pop_s   = 1'b0;
`ifdef LINK_MASTER_TIMEOUT_EN
    timer_d      = timer_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s && !bus.ack) begin
          fifo_pop_s = 1'b1;
          data_out_d = fifo_rd_data_s;
          req_d      = 1'b1;
          state_d    = S_REQ;
`ifdef LINK_MASTER_TIMEOUT_EN
          timer_d    = {TW{1'b0}};
`endif
        end else begin
          req_d = 1'b0;
        end
      end
      S_REQ: begin
        if (bus.ack) begin
          req_d   = 1'b0;
          state_d = S_WAIT_LOW;
`ifdef LINK_MASTER_TIMEOUT_EN
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 32'd1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
`else
        end else begin
          req_d   = 1'b1;
`endif
        end
      end
      S_WAIT_LOW: begin
        if (!bus.ack) begin
          byte_done_d  = 1'b1;
          sent_count_d = sent_count_q + 8'd1;
          state_d      = S_IDLE;
        end else begin
          req_d = 1'b0;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      data_out_q   <= 8'h00;
      byte_done_q  <= 1'b0;
      sent_count_q <= 8'h00;
`ifdef LINK_MASTER_TIMEOUT_EN
      timer_q      <= {TW{1'b0}};
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      data_out_q   <= data_out_d;
      byte_done_q  <= byte_done_d;
      sent_count_q <= sent_count_d;
`ifdef LINK_MASTER_TIMEOUT_EN
      timer_q      <= timer_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.in_ready   = !fifo_full_s;
  assign bus.req        = req_q;
  assign bus.data_out   = data_out_q;
  assign bus.byte_done  = byte_done_q;
  assign bus.sent_count = sent_count_q;
  assign bus.busy       = (state_q != S_IDLE) || (fifo_count_s != {CW{1'b0}});
`ifdef LINK_MASTER_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_link_master_fsm.sv
// Directed self-checking bench for link_master_fsm; the slave side is driven
// by hand from one linear initial block.
module tb_link_master_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  link_master_fsm_if bus ();

  link_master_fsm #(.DEPTH(4), .TIMEOUT_CYCLES(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.ack      = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Slave: ack one cycle after seeing req, hold it two cycles, then release.
  task automatic slave_xfer(input logic [7:0] exp, input string tag);
    int n = 0;
    while (bus.req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, "_req_high"}, 32'(bus.req), 32'd1);
    check({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    bus.ack = 1'b1;
    step();
    check({tag, "_req_drop"}, 32'(bus.req), 32'd0);
    step();
    check({tag, "_data_hold"}, 32'(bus.data_out), 32'(exp));
    bus.ack = 1'b0;
    step();
    check({tag, "_byte_done"}, 32'(bus.byte_done), 32'd1);
    step();
    check({tag, "_byte_done_pulse"}, 32'(bus.byte_done), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_byte_done", 32'(bus.byte_done), 32'd0);
    check("rst_sent_count", 32'(bus.sent_count), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single byte A5: req rises the edge after the push
    push_byte(8'hA5);
    check("a5_req_not_yet", 32'(bus.req), 32'd0);
    check("a5_busy", 32'(bus.busy), 32'd1);
    step();
    check("a5_req_latency", 32'(bus.req), 32'd1);
    slave_xfer(8'hA5, "a5");
    check("a5_sent_count", 32'(bus.sent_count), 32'd1);
    check("a5_busy_idle", 32'(bus.busy), 32'd0);

    // Back-to-back 01..05 then a refused push of 06 at full
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = 8'(i);
      check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_data = 8'h06;
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("full_refused_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      slave_xfer(8'(i), "b2b");
      if (i == 1) check("b2b_ready_after_pop", 32'(bus.in_ready), 32'd1);
      if (i == 4) check("b2b_busy_mid", 32'(bus.busy), 32'd1);
    end
    check("b2b_sent_count", 32'(bus.sent_count), 32'd5);
    check("b2b_busy_end", 32'(bus.busy), 32'd0);
    check("b2b_no_extra_req", 32'(bus.req), 32'd0);

    // Stale ack blocks the request until released
    do_reset();
    bus.ack = 1'b1;
    push_byte(8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stale_req_low", 32'(bus.req), 32'd0);
    end
    check("stale_busy", 32'(bus.busy), 32'd1);
    bus.ack = 1'b0;
    step();
    check("stale_req_rise", 32'(bus.req), 32'd1);
    slave_xfer(8'h3C, "stale");
    check("stale_sent_count", 32'(bus.sent_count), 32'd1);

    // Asynchronous reset in S_REQ with 3 bytes queued
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'hB1 + 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    check("mid_req_high", 32'(bus.req), 32'd1);
    check("mid_data", 32'(bus.data_out), 32'hB1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus.req), 32'd0);
    check("mid_rst_data", 32'(bus.data_out), 32'h00);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_sent_count", 32'(bus.sent_count), 32'd0);
    check("mid_rst_byte_done", 32'(bus.byte_done), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_req_low", 32'(bus.req), 32'd0);
      check("post_rst_busy_low", 32'(bus.busy), 32'd0);
    end

    // Non-responding slave
    do_reset();
    push_byte(8'h77);
    step();
    check("to_req_rise", 32'(bus.req), 32'd1);
`ifdef LINK_MASTER_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      step();
      check("to_req_held", 32'(bus.req), 32'd1);
    end
    step();
    check("to_req_drop", 32'(bus.req), 32'd0);
    check("to_err_set", 32'(bus.err), 32'd1);
    check("to_no_byte_done", 32'(bus.byte_done), 32'd0);
    check("to_busy", 32'(bus.busy), 32'd0);
    push_byte(8'h88);
    slave_xfer(8'h88, "to_next");
    check("to_err_sticky", 32'(bus.err), 32'd1);
    check("to_sent_count", 32'(bus.sent_count), 32'd1);
`else
    for (int i = 0; i < 30; i++) begin
      step();
      check("wait_req_held", 32'(bus.req), 32'd1);
    end
    check("wait_err_tied", 32'(bus.err), 32'd0);
    slave_xfer(8'h77, "wait");
    check("wait_sent_count", 32'(bus.sent_count), 32'd1);
    check("wait_err_after", 32'(bus.err), 32'd0);
`endif

    // 257 transfers: sent_count wraps to 01
    do_reset();
    for (int i = 0; i < 257; i++) begin
      push_byte(8'(i));
      slave_xfer(8'(i), "wrap");
      if (i == 254) check("wrap_count_ff", 32'(bus.sent_count), 32'hFF);
      if (i == 255) check("wrap_count_00", 32'(bus.sent_count), 32'h00);
    end
    check("wrap_count_01", 32'(bus.sent_count), 32'h01);
    check("wrap_err", 32'(bus.err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_master_fsm.md
LINK_MASTER_FSM -- requirements
Module: link_master_fsm

Interface
REQ-001 Parameter: DEPTH, 4, transmit FIFO entries (power of two, 2..16).
REQ-002 Parameter: TIMEOUT_CYCLES, 15, max cycles in S_REQ waiting for ack (used only with REQ-027).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 ack  input  1  acknowledge from slave.
REQ-009 req  output  1  request to slave, registered.
REQ-010 data_out  output  8  byte to slave, registered.
REQ-011 byte_done  output  1  one-cycle pulse per completed 4-phase transfer.
REQ-012 busy  output  1  high when FSM is not idle or FIFO is non-empty.
REQ-013 sent_count  output  8  completed transfers, modulo 256.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 Push when in_valid && in_ready; in_ready = !full; a push is refused at full even if a pop happens in the same cycle.
REQ-016 FSM states: S_IDLE, S_REQ, S_WAIT_LOW.
REQ-017 S_IDLE -> S_REQ when FIFO non-empty and ack==0: pop the head into data_out, set req=1 at the same edge.
REQ-018 S_IDLE with ack==1 (stale): req stays 0 and the FSM stays idle until ack==0.
REQ-019 S_REQ: req=1, data_out held stable; on sampled ack==1, req<=0 and go to S_WAIT_LOW.
REQ-020 S_WAIT_LOW: req=0; on sampled ack==0, pulse byte_done, increment sent_count, go to S_IDLE.
REQ-021 Latency: byte pushed at edge N into an empty FIFO with FSM idle and ack low gives req high after edge N+1.
REQ-022 req never rises while ack is high; data_out changes only on the S_IDLE->S_REQ edge.
REQ-023 Back-to-back: the next req rises no earlier than the edge after byte_done; minimum transfer is 4 cycles with a 1-cycle-ack slave.
REQ-024 sent_count wraps 255 -> 0 with no flag.
REQ-025 Simultaneous push and pop on a FIFO with exactly 1 entry: count stays 1, order preserved.
REQ-026 The FIFO preserves order; no byte is duplicated or dropped except per REQ-027.

Configuration
REQ-027 LINK_MASTER_TIMEOUT_EN defined: a counter runs in S_REQ; if ack stays 0 for TIMEOUT_CYCLES cycles, req<=0, err<=1 (sticky until rst), the byte is discarded without byte_done or count, and the FSM goes to S_IDLE.
REQ-028 LINK_MASTER_TIMEOUT_EN undefined: S_REQ waits indefinitely; err is tied 0; no timeout counter exists.

Reset
REQ-029 Asserting rst, at any point including mid-transfer: immediately req=0, data_out=8'h00, byte_done=0, sent_count=0, err=0, FIFO empty, in_ready=1, busy=0, state S_IDLE.
REQ-030 After rst deassertion, the first req needs a fresh push; bytes queued before reset are lost.

Structure
REQ-031 Shared package link_pkg holds the state enum (shared with the slave's encoding style), DEPTH default, and TIMEOUT_CYCLES default.
REQ-032 Sub-module link_fifo (synchronous, DEPTH x 8, full/empty, count) is instantiated once; the FSM, counters and timeout stay in the top module.

Verification
REQ-033 Push 8'hA5 with a slave acking 1 cycle after req and holding it 2 cycles -> req rises the cycle after the push; slave latches A5; one byte_done; sent_count=1.
REQ-034 Push 8'h01..8'h04 back-to-back -> four transfers in order 01,02,03,04; in_ready low only while full; sent_count=4; busy falls after the last byte_done.
REQ-035 Hold ack=1 before any push, then push 8'h3C -> req stays 0 until ack is released, then the transfer completes normally.
REQ-036 Assert rst while in S_REQ with 3 bytes queued -> req=0 immediately; FIFO empty; sent_count=0; no byte_done.
REQ-037 With LINK_MASTER_TIMEOUT_EN and a non-responding slave, push 8'h77 -> req drops after 15 cycles; err=1 and stays 1; sent_count unchanged; the next byte is still sent once the slave responds.
REQ-038 Send 257 bytes -> sent_count reads 8'h01 at the end.
